// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared types and constants for the PS/2 keyboard receiver.
//   ps2_state_e : deframer FSM states
//   PS2_EXT / PS2_BRK : prefix bytes folded into key_ext / key_break
//   KEY_LEFT / KEY_RIGHT / KEY_FIRE : scan codes of the tracked game keys
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_FIRE  = 8'h29;

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter -- synchroniser, glitch filter and falling-edge detect for
// the raw PS/2 pad lines.
//   clk, rst   : system clock, synchronous active-high reset
//   ps2_clk    : raw PS/2 clock (asynchronous)
//   ps2_data   : raw PS/2 data (asynchronous)
//   data_s     : synchronised data, same depth as the clock path
//   fall       : one-cycle strobe, registered one cycle after the filtered
//                clock goes 1->0
module ps2_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_s,
    output logic fall
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic [FW-1:0]          fcnt;
    logic                   filt;
    logic                   filt_d;

    // Both lines idle high, so the chains and the filter preset to 1 and
    // reset can never manufacture an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    // Filtered clock flips on the FILTER_LEN-th consecutive sample that
    // disagrees with it; any agreeing sample restarts the count, so pulses
    // shorter than FILTER_LEN cycles are swallowed.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt <= 1'b1;
            fcnt <= '0;
        end else if (clk_sync[SYNC_STAGES-1] == filt) begin
            fcnt <= '0;
        end else if (fcnt == FW'(FILTER_LEN - 1)) begin
            filt <= clk_sync[SYNC_STAGES-1];
            fcnt <= '0;
        end else begin
            fcnt <= fcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_d <= 1'b1;
            fall   <= 1'b0;
        end else begin
            filt_d <= filt;
            fall   <= filt_d & ~filt;
        end
    end

    assign data_s = dat_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx -- PS/2 keyboard receiver for the game core.
// Deframes 11-bit device-to-host frames, folds E0/F0 prefixes into flags and
// emits one-cycle key events.
//   clk, rst             : system clock, synchronous active-high reset
//   ps2_clk, ps2_data    : raw PS/2 pad lines (asynchronous)
//   key_valid            : one-cycle event strobe
//   key_code             : scan code (held between events)
//   key_break, key_ext   : F0 / E0 prefix seen for this event
//   frame_err            : one-cycle strobe on parity, stop or timeout error
//   key_left/right/fire  : held-key levels when PS2_KEYMAP_EN is defined,
//                          otherwise constant 0
// Optional feature macro: PS2_KEYMAP_EN
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_break,
    output logic       key_ext,
    output logic       frame_err,
    output logic       key_left,
    output logic       key_right,
    output logic       key_fire
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic       data_s;
    logic       fall;

    ps2_state_e state, state_nx;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       par_ok;
    logic [TW-1:0] to_cnt;
    logic       timeout;
    logic       byte_ok;
    logic       frm_err;
    logic       ext_pend;
    logic       brk_pend;

    ps2_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_filter (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .data_s   (data_s),
        .fall     (fall)
    );

    // A fall in the same cycle as expiry restarts the count, so fall wins.
    assign timeout = (state != ST_IDLE) && !fall &&
                     (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        byte_ok  = 1'b0;
        frm_err  = 1'b0;
        if (fall) begin
            case (state)
                ST_IDLE:   if (!data_s) state_nx = ST_DATA;
                ST_DATA:   if (bit_cnt == 3'd7) state_nx = ST_PARITY;
                ST_PARITY: state_nx = ST_STOP;
                ST_STOP: begin
                    state_nx = ST_IDLE;
                    if (data_s && par_ok) byte_ok = 1'b1;
                    else                  frm_err = 1'b1;
                end
                default:   state_nx = ST_IDLE;
            endcase
        end else if (timeout) begin
            state_nx = ST_IDLE;
            frm_err  = 1'b1;
        end
    end

    // Frame datapath: bit counter, LSB-first shifter, parity flag, timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            shreg   <= '0;
            par_ok  <= 1'b0;
            to_cnt  <= '0;
        end else begin
            if (fall || state == ST_IDLE) to_cnt <= '0;
            else                          to_cnt <= to_cnt + 1'b1;

            if (fall) begin
                case (state)
                    ST_IDLE: bit_cnt <= '0;
                    ST_DATA: begin
                        shreg   <= {data_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    // Odd parity: data bits plus parity bit XOR to 1.
                    ST_PARITY: par_ok <= ^{shreg, data_s};
                    default: ;
                endcase
            end
        end
    end

    // Byte decoder: prefixes only set pending flags; every other accepted
    // byte becomes an event and consumes them. Errors drop pending prefixes.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_valid <= 1'b0;
            frame_err <= 1'b0;
            key_code  <= '0;
            key_break <= 1'b0;
            key_ext   <= 1'b0;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            frame_err <= frm_err;
            if (frm_err) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end else if (byte_ok) begin
                if (shreg == PS2_EXT) begin
                    ext_pend <= 1'b1;
                end else if (shreg == PS2_BRK) begin
                    brk_pend <= 1'b1;
                end else begin
                    key_valid <= 1'b1;
                    key_code  <= shreg;
                    key_break <= brk_pend;
                    key_ext   <= ext_pend;
                    ext_pend  <= 1'b0;
                    brk_pend  <= 1'b0;
                end
            end
        end
    end

`ifdef PS2_KEYMAP_EN
    // Held-key levels follow the registered event, one cycle after key_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_left  <= 1'b0;
            key_right <= 1'b0;
            key_fire  <= 1'b0;
        end else if (key_valid) begin
            if (key_ext && key_code == KEY_LEFT)   key_left  <= !key_break;
            if (key_ext && key_code == KEY_RIGHT)  key_right <= !key_break;
            if (!key_ext && key_code == KEY_FIRE)  key_fire  <= !key_break;
        end
    end
`else
    assign key_left  = 1'b0;
    assign key_right = 1'b0;
    assign key_fire  = 1'b0;
`endif

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

PS/2 keyboard receiver feeding the shooting game core. Synchronises and de-glitches the raw pad-level `ps2_clk`/`ps2_data` inputs, deframes 11-bit device-to-host frames, folds the `E0` and `F0` prefix bytes into flags, and emits one-cycle key events. Optionally tracks held state for the three game keys. Sits directly between the PS/2 pads and the game logic, in the `clk` domain.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flops on each PS/2 line (≥2).
- `FILTER_LEN`, default 4: consecutive equal samples before the filtered `ps2_clk` changes.
- `TIMEOUT_CYCLES`, default 50000: idle `clk` cycles mid-frame before the frame is aborted.

- `clk`  in  1  system clock (LA-selectable `wb_clk_i`)
- `rst`  in  1  synchronous, active-high reset
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous
- `ps2_data`  in  1  raw PS/2 data, asynchronous
- `key_valid`  out  1  one-cycle event strobe
- `key_code`  out  8  scan code, valid with `key_valid`, held otherwise
- `key_break`  out  1  event was a release (`F0`-prefixed)
- `key_ext`  out  1  event was extended (`E0`-prefixed)
- `frame_err`  out  1  one-cycle strobe on parity, stop or timeout error
- `key_left`, `key_right`, `key_fire`  out  1 each  held-key levels (see Configuration)

## Operation
- Both lines pass through `SYNC_STAGES` flops. Filtered clock changes only after `FILTER_LEN` consecutive equal synchronised samples. Data uses the same synchroniser depth and is sampled at each filtered-clock falling edge (`fall` strobe).
- Frame FSM states:
  - `IDLE`: on `fall` with data=0 (start bit), go to `DATA` and clear the bit counter. Data=1 is ignored.
  - `DATA`: shift data in LSB-first. After the 8th bit, go to `PARITY`.
  - `PARITY`: store the parity-OK flag, computed as XOR(8 data bits, parity bit)=1 (odd parity). Go to `STOP`.
  - `STOP`: if data=1 and parity is OK, the byte is accepted. Otherwise pulse `frame_err`. Return to `IDLE` in either case.
- Timeout counter clears on every `fall` and counts in every non-`IDLE` state. When it reaches `TIMEOUT_CYCLES-1`, the FSM returns to `IDLE` and `frame_err` pulses. If `fall` occurs in the same cycle, `fall` wins and no timeout occurs.
- Byte decoder, for each accepted byte:
  - `E0`: set `ext_pend`.
  - `F0`: set `brk_pend`.
  - Any other byte (including `E1`, `FA`, `AA`): emit `key_valid`, `key_code`=byte, `key_break`=`brk_pend`, `key_ext`=`ext_pend`, then clear both pending flags.
- Any `frame_err` clears both pending flags.
- `key_valid` and `frame_err` are never high in the same cycle.

## Timing
- Reset (takes effect on the next `clk` edge): FSM `IDLE`, counters 0, pending flags 0. All outputs are 0, including `key_code`=8'h00. The filter state is preset to 1 (line idle). No strobe fires as a result of reset.
- Reset asserted mid-frame abandons the frame silently; no `frame_err` is raised.
- The filtered clock falls `SYNC_STAGES+FILTER_LEN` cycles after the raw fall.
- `key_valid`/`frame_err` are registered and go high the cycle after the `fall` that samples the stop bit.
- Raw stop-bit fall to strobe: `SYNC_STAGES+FILTER_LEN+2` cycles (8 at defaults).
- Flags and `key_code` update in the same cycle as `key_valid`.
- No back-pressure: the consumer must take each event on its strobe cycle.

## Configuration
- `PS2_KEYMAP_EN` defined:
  - `key_left` tracks extended `6B`, `key_right` tracks extended `74`, `key_fire` tracks non-extended `29` (space).
  - Each goes high on the make event and low on the matching break event, updating in the cycle after `key_valid`.
  - Non-extended `6B`/`74` and extended `29` do not affect them.
  - Errors do not clear held state; only reset does.
- `PS2_KEYMAP_EN` undefined: `key_left`, `key_right` and `key_fire` are constant 0, and no tracking logic is present.

## Structure
- Package `ps2_pkg`: frame FSM state enum; constants `PS2_EXT`=8'hE0, `PS2_BRK`=8'hF0, `KEY_LEFT`=8'h6B, `KEY_RIGHT`=8'h74, `KEY_FIRE`=8'h29.
- Sub-module `ps2_line_filter`: synchroniser plus glitch filter plus falling-edge detect. Outputs synchronised data and the `fall` strobe.
- Deframer, decoder and keymap stay in `ps2_keyboard_rx`.

## Test plan
- Frame `1C`, odd parity, 10 µs half-period → `key_valid` pulse, `key_code`=8'h1C, break=0, ext=0, exactly 8 cycles after the stop-bit fall.
- Sequence `E0 F0 6B` → one event: code 8'h6B, break=1, ext=1. `key_left` falls if it was previously set by `E0 6B`.
- Frame `29` with parity flipped → `frame_err` pulse and no `key_valid`. A following `29` produces an event with break=0, ext=0.
- Stop after 5 data bits for `TIMEOUT_CYCLES` → `frame_err` pulse, FSM returns to `IDLE`. The next full frame decodes correctly.
- Glitch pulses of `FILTER_LEN-1` cycles on `ps2_clk` mid-frame → no extra bits are shifted and the decoded code is unchanged.
- Assert `rst` after 4 data bits → all outputs 0 and no strobe. The next full frame `74` decodes as 8'h74.
